// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_access_unit                                                |
// | Purpose : Load/store unit that issues one data-memory bus transaction    |
// |           per accepted access. It validates size and alignment, places   |
// |           store data and byte masks on the bus lanes, and extracts and   |
// |           extends load data. A bounded wait on dmem_ready turns a hung   |
// |           bus into a faulted completion.                                 |
// | Ports   : clk, rst        - clock, asynchronous active-high reset        |
// |           start           - begin access (sampled only while idle)       |
// |           mem_read/write  - access is a load / store                     |
// |           funct3          - size/sign: B, H, W, BU, HU                   |
// |           addr, wdata     - byte address, store data                     |
// |           busy, done      - not idle, one-cycle completion pulse         |
// |           fault           - qualifies done: rejected or timed out        |
// |           rdata           - extended result of the last good load        |
// |           dmem_*          - word-aligned request/response bus            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  // The counter runs 0..TIMEOUT-1 across the REQ cycles of one access.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lane;
  logic              r_load;

  // ---------------------------------------------------------------------
  // Access decode, evaluated on the live inputs in the capture cycle; the
  // decision is made on the same edge that captures the access.
  // ---------------------------------------------------------------------
  logic        w_is_half;
  logic        w_is_word;
  logic        w_load_ok;
  logic        w_store_ok;
  logic        w_align_ok;
  logic        w_noop;
  logic        w_reject;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_mask;

  always_comb begin
    w_is_half  = (funct3[1:0] == 2'b01);   // H and HU
    w_is_word  = (funct3 == 3'b010);
    w_load_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_store_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    w_align_ok = !(w_is_half && addr[0]) && !(w_is_word && (addr[1:0] != 2'b00));
    w_noop     = !mem_read && !mem_write;
    w_reject   = (mem_read && mem_write)
               || (mem_read && !w_load_ok)
               || (mem_write && !w_store_ok)
               || (!w_noop && !w_align_ok);
  end

  // Store lane placement: data is replicated so the slave can pick any lane,
  // the mask selects which bytes actually get written.
  always_comb begin
    w_st_data = 32'h0;
    w_st_mask = 4'b0000;
    if (mem_write) begin
      case (funct3)
        3'b000: begin
          w_st_data = {4{wdata[7:0]}};
          w_st_mask = 4'b0001 << addr[1:0];
        end
        3'b001: begin
          w_st_data = {2{wdata[15:0]}};
          w_st_mask = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_st_data = wdata;
          w_st_mask = 4'b1111;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Load extraction from the bus word, using the captured size and lane.
  // ---------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'h0, w_byte};
      3'b101:  w_ld_data = {16'h0, w_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_funct3   <= 3'b000;
      r_lane     <= 2'b00;
      r_load     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      rdata      <= 32'h0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_wmask <= 4'b0000;
    end else begin
      // done/fault are pulses; they are only raised on entry to DONE.
      done  <= 1'b0;
      fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_funct3 <= funct3;
            r_lane   <= addr[1:0];
            r_load   <= mem_read;
            r_cnt    <= '0;
            busy     <= 1'b1;
            if (w_reject || w_noop) begin
              // Nothing goes on the bus; complete straight away.
              r_state <= ST_DONE;
              done    <= 1'b1;
              fault   <= w_reject;
            end else begin
              r_state    <= ST_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_wdata <= w_st_data;
              dmem_wmask <= w_st_mask;
            end
          end
        end

        ST_REQ: begin
          if (dmem_ready) begin
            r_state    <= ST_DONE;
            done       <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wmask <= 4'b0000;
            r_cnt      <= '0;
            if (r_load) begin
              rdata <= w_ld_data;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            // Bus never answered: abandon the request, rdata untouched.
            r_state    <= ST_DONE;
            done       <= 1'b1;
            fault      <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wmask <= 4'b0000;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here.
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mem_access_unit                                             |
// | Purpose : Scoreboard bench for mem_access_unit. Each access pushes its   |
// |           expected bus view and result; a negedge monitor plays the bus  |
// |           slave, checks every request cycle and every completion.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] baddr;
    logic        we;
    logic [31:0] bwdata;
    logic [3:0]  mask;
    int          rdy_at;     // REQ cycle index (0-based) of ready, -1 = never
    logic [31:0] bus_rdata;
    int          n_req;
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   req_seen = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus slave + scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      dmem_ready = 1'b0;
    end else begin
      if (!done) check_val("fault_without_done", fault, 0);
      if (dmem_req) begin
        req_seen++;
        if (sb.size() == 0) begin
          check_val("unexpected_req", dmem_req, 0);
          dmem_ready = 1'b0;
        end else begin
          check_val("dmem_addr", dmem_addr, sb[0].baddr);
          check_val("dmem_we", dmem_we, sb[0].we);
          check_val("dmem_wmask", dmem_wmask, sb[0].mask);
          if (sb[0].we) check_val("dmem_wdata", dmem_wdata, sb[0].bwdata);
          dmem_ready = (sb[0].rdy_at >= 0) && (req_seen == sb[0].rdy_at + 1);
        end
      end else begin
        dmem_ready = 1'b0;
      end
      dmem_rdata = (dmem_ready && sb.size() != 0) ? sb[0].bus_rdata : $urandom;
      if (done) begin
        if (sb.size() == 0) begin
          check_val("extra_done", done, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("done_fault", fault, mon_e.fault);
          check_val("done_rdata", rdata, mon_e.rdata);
          check_val("req_cycles", req_seen, mon_e.n_req);
          check_val("req_low_at_done", dmem_req, 0);
          check_val("busy_at_done", busy, 1);
        end
        req_seen = 0;
      end
    end
  end

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] brd, input int rdy, input int nreq,
                            input logic ef, input logic [31:0] er,
                            input logic [31:0] ewd, input logic [3:0] emask,
                            input logic tog);
    exp_t e;
    int   n;
    bit   seen;
    e.baddr = {a[31:2], 2'b00};
    e.we = wr;
    e.bwdata = ewd;
    e.mask = emask;
    e.rdy_at = rdy;
    e.bus_rdata = brd;
    e.n_req = nreq;
    e.fault = ef;
    e.rdata = er;
    sb.push_back(e);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      // Scramble inputs after capture; they must not affect the access.
      addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      start = tog ? (n % 2 == 0) : 1'b0;
      if (done) seen = 1;
      else check_val("busy_in_flight", busy, 1);
    end
    check_val("done_seen", seen, 1);
    check_val("latency", n, nreq + 1);
    if (tog) start = 1'b1;   // start while in DONE must be ignored
    @(negedge clk);
    start = 1'b0;
    check_val("done_one_cycle", done, 0);
    check_val("idle_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_req", dmem_req, 0);
    check_val("rst_we", dmem_we, 0);
    check_val("rst_addr", dmem_addr, 0);
    check_val("rst_wdata", dmem_wdata, 0);
    check_val("rst_wmask", dmem_wmask, 0);
    rst = 1'b0;

    //          rd wr f3    addr          wdata         bus rdata     rdy nreq f  rdata         st wdata      mask     tog
    run_access(1, 0, 3'd0, 32'h0000_1003, 32'h0,        32'h8000_0000, 0, 1, 0, 32'hFFFF_FF80, 32'h0,        4'b0000, 0);
    run_access(0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,       1, 2, 0, 32'hFFFF_FF80, 32'hABCD_ABCD, 4'b1100, 0);
    run_access(1, 0, 3'd2, 32'h0000_3001, 32'h0,        32'h0,        -1, 0, 1, 32'hFFFF_FF80, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd5, 32'h0000_4002, 32'h0,        32'h0,        -1, 4, 1, 32'hFFFF_FF80, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd4, 32'h0000_5001, 32'h0,        32'h1122_F344, 2, 3, 0, 32'h0000_00F3, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd1, 32'h0000_5002, 32'h0,        32'h8001_7FFF, 0, 1, 0, 32'hFFFF_8001, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd5, 32'h0000_5000, 32'h0,        32'h8001_9ABC, 0, 1, 0, 32'h0000_9ABC, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd2, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 1, 2, 0, 32'hDEAD_BEEF, 32'h0,        4'b0000, 1);
    run_access(0, 1, 3'd0, 32'h0000_7001, 32'hAABB_CC5A, 32'h0,       0, 1, 0, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 4'b0010, 0);
    run_access(0, 1, 3'd2, 32'h0000_7004, 32'h0102_0304, 32'h0,       0, 1, 0, 32'hDEAD_BEEF, 32'h0102_0304, 4'b1111, 0);
    run_access(0, 1, 3'd1, 32'h0000_7000, 32'hFFFF_8765, 32'h0,       0, 1, 0, 32'hDEAD_BEEF, 32'h8765_8765, 4'b0011, 0);
    run_access(1, 1, 3'd2, 32'h0000_7000, 32'h0,        32'h0,        -1, 0, 1, 32'hDEAD_BEEF, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd3, 32'h0000_7000, 32'h0,        32'h0,        -1, 0, 1, 32'hDEAD_BEEF, 32'h0,        4'b0000, 0);
    run_access(0, 1, 3'd4, 32'h0000_7000, 32'h0,        32'h0,        -1, 0, 1, 32'hDEAD_BEEF, 32'h0,        4'b0000, 0);
    run_access(0, 0, 3'd2, 32'h0000_7003, 32'h0,        32'h0,        -1, 0, 0, 32'hDEAD_BEEF, 32'h0,        4'b0000, 0);
    run_access(0, 1, 3'd2, 32'h0000_7002, 32'h0,        32'h0,        -1, 0, 1, 32'hDEAD_BEEF, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd1, 32'h0000_9001, 32'h0,        32'h0,        -1, 0, 1, 32'hDEAD_BEEF, 32'h0,        4'b0000, 0);
    run_access(1, 0, 3'd0, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1, 0, 32'h0000_007F, 32'h0,        4'b0000, 0);
    run_access(0, 1, 3'd0, 32'h0000_A003, 32'h0000_0011, 32'h0,       -1, 4, 1, 32'h0000_007F, 32'h1111_1111, 4'b1000, 0);

    // Reset in the middle of a request that the bus never answers.
    e.baddr = 32'h0000_8000; e.we = 1'b0; e.bwdata = 32'h0; e.mask = 4'b0000;
    e.rdy_at = -1; e.bus_rdata = 32'h0; e.n_req = 0; e.fault = 1'b0; e.rdata = 32'h0;
    sb.push_back(e);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h0000_8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("pre_rst_req", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_req", dmem_req, 0);
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_rdata", rdata, 0);
    check_val("async_rst_addr", dmem_addr, 0);
    sb.delete();
    req_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    run_access(1, 0, 3'd2, 32'h0000_8004, 32'h0, 32'h1357_9BDF, 0, 1, 0, 32'h1357_9BDF, 32'h0, 4'b0000, 0);

    repeat (3) @(negedge clk);
    check_val("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in REQ without dmem_ready before the access aborts with fault.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin access; sampled only in IDLE.
REQ-005 mem_read  input  1  access is a load.
REQ-006 mem_write  input  1  access is a store.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data (rs2 value).
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 fault  output  1  qualifies done: access rejected or timed out.
REQ-013 rdata  output  32  load result, extended to 32 bits.
REQ-014 dmem_req  output  1  bus request.
REQ-015 dmem_we  output  1  bus write enable.
REQ-016 dmem_addr  output  32  word-aligned bus address.
REQ-017 dmem_wdata  output  32  lane-replicated store data.
REQ-018 dmem_wmask  output  4  byte-lane write mask.
REQ-019 dmem_ready  input  1  bus accepts/completes request this cycle.
REQ-020 dmem_rdata  input  32  bus read word, valid when dmem_ready=1.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, DONE.
REQ-022 In IDLE with start=1, addr, wdata, funct3, mem_read and mem_write SHALL be captured into registers; later input changes SHALL NOT affect the access.
REQ-023 A captured access SHALL be rejected when: mem_read and mem_write both 1; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}; H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-024 A rejected access, or one with mem_read=mem_write=0, SHALL go IDLE->DONE with no dmem_req; fault=1 only for rejection.
REQ-025 A valid access SHALL go IDLE->REQ, driving dmem_req=1, dmem_we=mem_write, dmem_addr={addr[31:2],2'b00}, all stable until dmem_ready.
REQ-026 In REQ, a cycle with dmem_ready=1 SHALL end the request; next state DONE, fault=0.
REQ-027 Latency: start high at edge N; dmem_req high in cycle N..N+1 window from edge N; ready in the first REQ cycle gives done in the following cycle (2 cycles start-to-done minimum).
REQ-028 A cycle counter SHALL count REQ cycles; reaching TIMEOUT without dmem_ready SHALL drop dmem_req, enter DONE with fault=1.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-030 Store lanes: SB dmem_wdata={4{wdata[7:0]}}, wmask=0001<<addr[1:0]; SH dmem_wdata={2{wdata[15:0]}}, wmask 0011 (addr[1]=0) or 1100; SW wmask=1111; loads wmask=0000.
REQ-031 Load extraction on the dmem_ready cycle: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through; result registered into rdata.
REQ-032 rdata SHALL hold its value until the next successful load; stores, faults and timeouts SHALL NOT change it.
REQ-033 fault SHALL be 0 whenever done=0.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, busy=0, done=0, fault=0, rdata=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wmask=0, counter=0, including mid-access.
REQ-035 After rst release, the first start SHALL be accepted on the first rising edge.

Verification
REQ-036 LB addr=0x1003, dmem_rdata=0x80_00_00_00, ready in first REQ cycle -> dmem_addr=0x1000, done 2 cycles after start, rdata=0xFFFFFF80, fault=0.
REQ-037 SH addr=0x2002, wdata=0x1234ABCD -> dmem_we=1, dmem_wdata=0xABCDABCD, dmem_wmask=1100; rdata unchanged.
REQ-038 LW addr=0x3001 -> no dmem_req, done+fault next cycle, busy high exactly one cycle.
REQ-039 TIMEOUT=4, LHU with dmem_ready held 0 -> dmem_req high 4 cycles, then done+fault, dmem_req=0.
REQ-040 rst asserted during REQ with ready=0 -> dmem_req and busy drop without a clock edge; next start after release proceeds normally.
REQ-041 start toggled while busy -> ignored; exactly one done per accepted access.
